// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port RAM between the instruction-fetch and data-access
// request strobes of the processor datapath. Data accesses win arbitration,
// but a saturating streak counter forces an instruction grant after
// MAX_DSTREAK consecutive data grants taken while a fetch was waiting.
// Every RAM-side output comes from registers latched at grant time, so the
// RAM sees a stable address, store word and strobe for the whole access.
// Each access ends with a one-cycle RESP state that pulses ihit or dhit. The
// next request is sampled in the IDLE state that follows RESP.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   imemREN, imemaddr   instruction fetch request and address
//   dmemREN, dmemWEN    data read / write request (write wins if both high)
//   dmemaddr, dmemstore data address and write data
//   ihit, imemload      fetch-complete pulse and fetched word (held)
//   dhit, dmemload      data-complete pulse and read word (held)
//   ramREN, ramWEN      RAM read / write strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramready   RAM read data and access-complete flag
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DACC,
        IRESP,
        DRESP
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic              wr_q;
    logic [3:0]        streak;

    logic dreq;
    logic streak_full;
    logic grant_d;
    logic grant_i;

    assign dreq        = dmemREN | dmemWEN;
    assign streak_full = (streak == STREAK_MAX);

    // RAM address and store word come only from the grant-time latches.
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    // Next state, grant decision and decoded strobes/hits.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ihit       = 1'b0;
        dhit       = 1'b0;

        case (state)
            IDLE: begin
                // A waiting fetch pre-empts data once the streak is spent.
                if (dreq && !(imemREN && streak_full)) begin
                    grant_d    = 1'b1;
                    next_state = DACC;
                end else if (imemREN) begin
                    grant_i    = 1'b1;
                    next_state = IACC;
                end
            end
            IACC: begin
                ramREN = 1'b1;
                if (ramready) next_state = IRESP;
            end
            DACC: begin
                ramREN = ~wr_q;
                ramWEN = wr_q;
                if (ramready) next_state = DRESP;
            end
            IRESP: begin
                ihit       = 1'b1;
                next_state = IDLE;
            end
            DRESP: begin
                dhit       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state    <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            streak   <= '0;
            imemload <= '0;
            dmemload <= '0;
        end else begin
            state <= next_state;

            if (grant_d) begin
                addr_q  <= dmemaddr;
                store_q <= dmemstore;
                wr_q    <= dmemWEN;
                // Only data grants that bypass a waiting fetch count.
                if (imemREN) begin
                    streak <= streak_full ? streak : streak + 4'd1;
                end else begin
                    streak <= '0;
                end
            end

            if (grant_i) begin
                addr_q <= imemaddr;
                wr_q   <= 1'b0;
                streak <= '0;
            end

            if (state == IACC && ramready) imemload <= ramload;
            if (state == DACC && ramready && !wr_q) dmemload <= ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. A transaction-level model decides each
// grant from the arbitration rules and pushes the expected hit into a
// queue. A monitor on the falling edge pops and compares whenever a
// response is due, and checks the RAM-side outputs of every access cycle.
// A behavioural RAM answers the DUT with random wait states.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int W    = 32;
    localparam int MAXD = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         imemREN, dmemREN, dmemWEN;
    logic [W-1:0] imemaddr, dmemaddr, dmemstore;
    logic         ihit, dhit, ramREN, ramWEN, ramready;
    logic [W-1:0] imemload, dmemload, ramaddr, ramstore, ramload;

    mem_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .dmemaddr (dmemaddr),
        .dmemstore(dmemstore),
        .ihit     (ihit),
        .dhit     (dhit),
        .imemload (imemload),
        .dmemload (dmemload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit           kind;  // 1 = data, 0 = instruction
        logic [W-1:0] load;
    } exp_t;

    typedef enum int {M_FREE, M_ACC, M_RESP} mphase_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    bit           hit_log[$];
    logic [W-1:0] ram_mem[logic [W-1:0]];
    logic [W-1:0] ref_mem[logic [W-1:0]];

    mphase_t      m_phase  = M_FREE;
    bit           m_kind   = 1'b0;
    bit           m_wr     = 1'b0;
    logic [W-1:0] m_addr   = '0;
    logic [W-1:0] m_store  = '0;
    logic [W-1:0] m_iload  = '0;
    logic [W-1:0] m_dload  = '0;
    int           m_streak = 0;

    int p_ready   = 100;
    int n_waits   = 0;   // negative: random 0..3 per access
    int wait_left = 0;
    bit hold_mode = 1'b0;
    bit drop_en   = 1'b0;
    bit auto_req  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [W-1:0] ram_rd(input logic [W-1:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [W-1:0] rand_addr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic preload(input logic [W-1:0] a, input logic [W-1:0] v);
        ram_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Reference model: advances one transaction phase per rising edge using
    // the request and ready values the bench held during the ending cycle.
    task automatic model_edge();
        exp_t ne;
        if (RST) begin
            m_phase   = M_FREE;
            m_streak  = 0;
            m_iload   = '0;
            m_dload   = '0;
            wait_left = 0;
            exp_q.delete();
            return;
        end
        case (m_phase)
            M_FREE: begin
                if (dmemREN || dmemWEN || imemREN) begin
                    if ((dmemREN || dmemWEN) && !(imemREN && m_streak == MAXD)) begin
                        m_kind   = 1'b1;
                        m_wr     = dmemWEN;
                        m_addr   = dmemaddr;
                        m_store  = dmemstore;
                        m_streak = imemREN ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
                        if (!m_wr) m_dload = ref_rd(m_addr);
                        ne.load = m_dload;
                    end else begin
                        m_kind   = 1'b0;
                        m_wr     = 1'b0;
                        m_addr   = imemaddr;
                        m_streak = 0;
                        m_iload  = ref_rd(m_addr);
                        ne.load  = m_iload;
                    end
                    ne.kind = m_kind;
                    exp_q.push_back(ne);
                    wait_left = (n_waits < 0) ? int'($urandom_range(0, 3)) : n_waits;
                    m_phase   = M_ACC;
                end
            end
            M_ACC: begin
                if (ramready) begin
                    if (m_wr) ref_mem[m_addr] = m_store;
                    m_phase = M_RESP;
                end
            end
            default: m_phase = M_FREE;
        endcase
    endtask

    task automatic drive_ram();
        if (m_phase == M_ACC && wait_left > 0) begin
            ramready = 1'b0;
            wait_left--;
        end else begin
            ramready = ($urandom_range(0, 99) < p_ready);
        end
        ramload = ramready ? ram_rd(ramaddr) : W'($urandom());
    endtask

    // Request unit: drops the serviced strobe during RESP and, in random
    // mode, raises new requests and sometimes abandons a data request
    // mid-access.
    task automatic drive_reqs();
        if (m_phase == M_RESP && !hold_mode) begin
            if (m_kind) begin
                dmemREN = 1'b0;
                dmemWEN = 1'b0;
            end else begin
                imemREN = 1'b0;
            end
        end
        if (drop_en && m_phase == M_ACC && m_kind && $urandom_range(0, 3) == 0) begin
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
        end
        if (auto_req) begin
            if (!imemREN && !(m_phase != M_FREE && !m_kind) && $urandom_range(0, 1) == 1) begin
                imemREN  = 1'b1;
                imemaddr = rand_addr();
            end
            if (!(dmemREN || dmemWEN) && !(m_phase != M_FREE && m_kind)
                && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0:       dmemREN = 1'b1;
                    1:       dmemWEN = 1'b1;
                    default: begin
                        dmemREN = 1'b1;
                        dmemWEN = 1'b1;
                    end
                endcase
                dmemaddr  = rand_addr();
                dmemstore = W'($urandom());
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        drive_ram();
        drive_reqs();
    endtask

    // Behavioural RAM write port.
    always @(negedge CLK) begin
        if (!RST && ramWEN && ramready) ram_mem[ramaddr] = ramstore;
    end

    // Monitor: RAM-side checks every cycle, hit checks against the queue.
    always @(negedge CLK) begin
        check("hit_overlap", 32'(ihit & dhit), 32'd0);
        if (m_phase == M_ACC) begin
            check("ramREN", 32'(ramREN), 32'(!m_wr));
            check("ramWEN", 32'(ramWEN), 32'(m_wr));
            check("ramaddr", ramaddr, m_addr);
            if (m_wr) check("ramstore", ramstore, m_store);
        end else begin
            check("ram_strobes_off", 32'({ramREN, ramWEN}), 32'd0);
        end
        if (m_phase == M_RESP) begin
            if (exp_q.size() == 0) begin
                check("hit_queue_empty", 32'd0, 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("ihit", 32'(ihit), 32'(!mon_e.kind));
                check("dhit", 32'(dhit), 32'(mon_e.kind));
                if (mon_e.kind) check("dmemload", dmemload, mon_e.load);
                else            check("imemload", imemload, mon_e.load);
            end
        end else begin
            check("stray_hit", 32'({ihit, dhit}), 32'd0);
        end
        if (ihit || dhit) hit_log.push_back(dhit);
    end

    initial begin
        RST       = 1'b1;
        imemREN   = 1'b0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        imemaddr  = '0;
        dmemaddr  = '0;
        dmemstore = '0;
        ramready  = 1'b0;
        ramload   = '0;

        // Reset state.
        repeat (2) cycle();
        RST = 1'b0;
        @(negedge CLK);
        check("reset_imemload", imemload, 32'd0);
        check("reset_dmemload", dmemload, 32'd0);
        check("reset_ramaddr", ramaddr, 32'd0);
        check("reset_ramstore", ramstore, 32'd0);

        // Single fetch, RAM always ready.
        preload(32'h40, 32'h8C01_0004);
        p_ready  = 100;
        n_waits  = 0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        repeat (4) cycle();
        check("fetch_word", imemload, 32'h8C01_0004);

        // Write with three wait cycles.
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h100;
        dmemstore = 32'hDEAD_BEEF;
        n_waits   = 3;
        repeat (7) cycle();
        n_waits = 0;
        check("write_landed", ram_rd(32'h100), 32'hDEAD_BEEF);
        check("write_keeps_dmemload", dmemload, 32'd0);

        // Priority: data first, then the waiting fetch.
        hit_log.delete();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        dmemREN  = 1'b1;
        dmemaddr = 32'h100;
        repeat (8) cycle();
        check("prio_hits", 32'(hit_log.size()), 32'd2);
        if (hit_log.size() >= 2) begin
            check("prio_first_data", 32'(hit_log[0]), 32'd1);
            check("prio_then_fetch", 32'(hit_log[1]), 32'd0);
        end
        check("prio_read_word", dmemload, 32'hDEAD_BEEF);

        // Starvation guard: both strobes held high continuously.
        hit_log.delete();
        hold_mode = 1'b1;
        imemREN   = 1'b1;
        dmemREN   = 1'b1;
        repeat (30) cycle();
        hold_mode = 1'b0;
        imemREN   = 1'b0;
        dmemREN   = 1'b0;
        repeat (5) cycle();
        if (hit_log.size() < 10) begin
            check("starve_hit_count", 32'(hit_log.size()), 32'd10);
        end else begin
            for (int i = 0; i < 10; i++) begin
                check("starve_pattern", 32'(hit_log[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
            end
        end

        // Data read request abandoned mid-access still completes once.
        hit_log.delete();
        dmemREN  = 1'b1;
        dmemaddr = 32'h40;
        n_waits  = 2;
        cycle();
        dmemREN = 1'b0;
        repeat (6) cycle();
        n_waits = 0;
        check("drop_hit_count", 32'(hit_log.size()), 32'd1);
        check("drop_read_word", dmemload, 32'h8C01_0004);

        // Reset in the middle of a stalled write.
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h80;
        dmemstore = 32'h1234_5678;
        n_waits   = 50;
        repeat (2) cycle();
        RST     = 1'b1;
        dmemWEN = 1'b0;
        repeat (2) cycle();
        RST     = 1'b0;
        n_waits = 0;
        @(negedge CLK);
        check("rst_mid_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_mid_dhit", 32'(dhit), 32'd0);
        check("rst_mid_imemload", imemload, 32'd0);
        check("rst_mid_no_write", ram_rd(32'h80), init_val(32'h80));

        // Randomized traffic with random wait states and abandoned requests.
        n_waits  = -1;
        p_ready  = 60;
        auto_req = 1'b1;
        drop_en  = 1'b1;
        repeat (3000) cycle();
        auto_req = 1'b0;
        drop_en  = 1'b0;
        imemREN  = 1'b0;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        p_ready  = 100;
        n_waits  = 0;
        repeat (10) cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
